s32x_vdp_bus_arb: RTL and testbench

//  Upstream bus front-end of the 32X VDP. Arbitrates VDP accesses from the MD 68K and the two SH2s.

---
 rtl/s32x_vdp_bus_arb.sv | 153 +++++++++++++++
 tb/tb_s32x_vdp_bus_arb.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s32x_vdp_bus_arb.sv
// 32X VDP upstream bus front-end: round-robin arbitration of the 68K and two SH2s onto the
// VDP strobe/select bus, with ACK_N handshake, FM ownership rejects and timeout abandonment.
module s32x_vdp_bus_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fm,
    input  logic [2:0]       rq_req,
    input  logic [2:0][16:0] rq_a,
    input  logic [2:0][15:0] rq_d,
    input  logic [2:0][1:0]  rq_we,
    input  logic [2:0][1:0]  rq_sel,
    output logic [15:0]      rq_q,
    output logic [2:0]       rq_ack,
    output logic [2:0]       rq_err,
    output logic [16:0]      a,
    output logic [15:0]      wr_data,
    input  logic [15:0]      rd_data,
    output logic             rd_n,
    output logic             lwr_n,
    output logic             uwr_n,
    output logic             reg_cs_n,
    output logic             pal_cs_n,
    output logic             dram_cs_n,
    input  logic             ack_n
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, RELEASE, DONE} state_t;

    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
    localparam logic [1:0] SEL_RSVD    = 2'd3;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] gnt;
    logic [1:0] we_l;
    logic       err_l;
    logic [9:0] cnt;

    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic       reject;
    logic [9:0] cnt_inc;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Scan from the pointer outwards; the last hit written is the closest one at/after ptr.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default before any branch,
        // otherwise the tool infers a latch for the paths that do not assign it.
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        for (int k = 2; k >= 0; k--) begin
            if (rq_req[wrap3(3'(ptr) + 3'(k))]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap3(3'(ptr) + 3'(k));
            end
        end
    end

    assign reject  = (fm ? (gnt_idx == 2'd0) : (gnt_idx != 2'd0)) || (rq_sel[gnt_idx] == SEL_RSVD);
    assign cnt_inc = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 2'd0;
            we_l      <= 2'b00;
            err_l     <= 1'b0;
            cnt       <= '0;
            rq_q      <= '0;
            rq_ack    <= '0;
            rq_err    <= '0;
            a         <= '0;
            wr_data   <= '0;
            rd_n      <= 1'b1;
            lwr_n     <= 1'b1;
            uwr_n     <= 1'b1;
            reg_cs_n  <= 1'b1;
            pal_cs_n  <= 1'b1;
            dram_cs_n <= 1'b1;
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments so every
            // branch reads the pre-edge values; later assignments override the pulse defaults.
            rq_ack <= '0;
            rq_err <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        ptr <= wrap3(3'(gnt_idx) + 3'd1);
                        gnt <= gnt_idx;
                        if (reject) begin
                            rq_q             <= '0;
                            rq_ack[gnt_idx]  <= 1'b1;
                            rq_err[gnt_idx]  <= 1'b1;
                            state            <= DONE;
                        end else begin
                            a         <= rq_a[gnt_idx];
                            wr_data   <= rq_d[gnt_idx];
                            we_l      <= rq_we[gnt_idx];
                            err_l     <= 1'b0;
                            reg_cs_n  <= (rq_sel[gnt_idx] != 2'd0);
                            pal_cs_n  <= (rq_sel[gnt_idx] != 2'd1);
                            dram_cs_n <= (rq_sel[gnt_idx] != 2'd2);
                            state     <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    cnt <= '0;
                    if (we_l == 2'b00) begin
                        rd_n <= 1'b0;
                    end else begin
                        lwr_n <= ~we_l[0];
                        uwr_n <= ~we_l[1];
                    end
                    state <= STROBE;
                end
                STROBE: state <= WAIT;
                WAIT: begin
                    // An ack in the same cycle the timeout expires still wins.
                    if (!ack_n || (cnt_inc >= TIMEOUT_CNT)) begin
                        rq_q      <= ack_n ? 16'hFFFF : rd_data;
                        err_l     <= ack_n;
                        rd_n      <= 1'b1;
                        lwr_n     <= 1'b1;
                        uwr_n     <= 1'b1;
                        reg_cs_n  <= 1'b1;
                        pal_cs_n  <= 1'b1;
                        dram_cs_n <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE: begin
                    if (ack_n) begin
                        rq_ack[gnt] <= 1'b1;
                        rq_err[gnt] <= err_l;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s32x_vdp_bus_arb.sv
// Scoreboard bench for s32x_vdp_bus_arb: a transaction-level model predicts grant order and
// results, a VDP responder plays ACK_N, and a monitor checks every RQ_ACK pulse.
module tb_s32x_vdp_bus_arb;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fm = 1'b0;
    logic [2:0]       rq_req = '0;
    logic [2:0][16:0] rq_a = '0;
    logic [2:0][15:0] rq_d = '0;
    logic [2:0][1:0]  rq_we = '0;
    logic [2:0][1:0]  rq_sel = '0;
    logic [15:0]      rq_q;
    logic [2:0]       rq_ack;
    logic [2:0]       rq_err;
    logic [16:0]      a;
    logic [15:0]      wr_data;
    logic [15:0]      rd_data = '0;
    logic             rd_n, lwr_n, uwr_n, reg_cs_n, pal_cs_n, dram_cs_n;
    logic             ack_n = 1'b1;

    always #5 clk = ~clk;

    s32x_vdp_bus_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .fm(fm),
        .rq_req(rq_req), .rq_a(rq_a), .rq_d(rq_d), .rq_we(rq_we), .rq_sel(rq_sel),
        .rq_q(rq_q), .rq_ack(rq_ack), .rq_err(rq_err),
        .a(a), .wr_data(wr_data), .rd_data(rd_data),
        .rd_n(rd_n), .lwr_n(lwr_n), .uwr_n(uwr_n),
        .reg_cs_n(reg_cs_n), .pal_cs_n(pal_cs_n), .dram_cs_n(dram_cs_n),
        .ack_n(ack_n)
    );

    typedef struct {
        logic [1:0]  who;
        logic        err;
        logic [15:0] q;
    } exp_t;

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
        logic [1:0]  we;
        logic [1:0]  sel;
        int          delay;
        int          hold;
        logic [15:0] di;
    } bus_t;

    exp_t exp_q[$];
    bus_t bus_q[$];
    int   tests = 0;
    int   fails = 0;
    int   mptr  = 0;

    logic [16:0] s_a[3];
    logic [15:0] s_d[3];
    logic [1:0]  s_we[3];
    logic [1:0]  s_sel[3];
    int          s_delay[3];
    int          s_hold[3];
    logic [15:0] s_di[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_req(input int b);
        s_a[b]     = 17'($urandom);
        s_d[b]     = 16'($urandom);
        s_we[b]    = 2'($urandom);
        s_sel[b]   = 2'($urandom);
        s_delay[b] = $urandom_range(0, 12);
        s_hold[b]  = $urandom_range(0, 2);
        s_di[b]    = 16'($urandom);
    endtask

    // Model: requests in 'set' are all raised together; predict grant order, bus cycles and results.
    task automatic run_round(input logic [2:0] set, input logic f, input bit toggle_fm, input bit drop_early);
        logic [2:0] pending;
        logic [2:0] done;
        int         g;
        int         lat;
        int         n;
        bit         single;
        @(negedge clk);
        single  = ($countones(set) == 1);
        pending = set;
        lat     = 0;
        while (pending != 3'b000) begin
            g = -1;
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (mptr + k) % 3;
                if (g < 0 && pending[c]) g = c;
            end
            mptr       = (g + 1) % 3;
            pending[g] = 1'b0;
            if ((f ? (g == 0) : (g != 0)) || s_sel[g] == 2'd3) begin
                exp_q.push_back('{2'(g), 1'b1, 16'h0000});
                lat = 1;
            end else begin
                bus_q.push_back('{s_a[g], s_d[g], s_we[g], s_sel[g], s_delay[g], s_hold[g], s_di[g]});
                if (s_delay[g] > TO) begin
                    exp_q.push_back('{2'(g), 1'b1, 16'hFFFF});
                    lat = 3 + TO + 1;
                end else begin
                    exp_q.push_back('{2'(g), 1'b0, s_di[g]});
                    lat = 3 + ((s_delay[g] < 1) ? 1 : s_delay[g]) + 1 + s_hold[g];
                end
            end
        end
        fm = f;
        for (int b = 0; b < 3; b++) begin
            rq_a[b]   = s_a[b];
            rq_d[b]   = s_d[b];
            rq_we[b]  = s_we[b];
            rq_sel[b] = s_sel[b];
        end
        rq_req = set;
        done   = 3'b000;
        n      = 0;
        while (done != set && n < 300) begin
            @(negedge clk);
            n++;
            if (toggle_fm && n == 2) fm = ~fm;
            if (drop_early && n == 2) rq_req = 3'b000;
            for (int b = 0; b < 3; b++) begin
                if (rq_ack[b] && set[b] && !done[b]) begin
                    done[b]   = 1'b1;
                    rq_req[b] = 1'b0;
                    if (single) check("latency", n, lat);
                end
            end
        end
        check("round_done", {29'b0, done}, {29'b0, set});
    endtask

    // Monitor: bus invariants every cycle, scoreboard pop on each completion pulse.
    exp_t       mon_e;
    logic [2:0] mon_cs_low;
    always @(negedge clk) begin
        if (rst_n) begin
            mon_cs_low = ~{reg_cs_n, pal_cs_n, dram_cs_n};
            check("cs_onehot", ($countones(mon_cs_low) <= 1), 1);
            check("strobe_has_cs", ((rd_n && lwr_n && uwr_n) || (mon_cs_low != 3'b000)), 1);
            check("ack_onehot", ($countones(rq_ack) <= 1), 1);
            check("err_with_ack", ((rq_err & ~rq_ack) == 3'b000), 1);
            if (rq_ack != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", {29'b0, rq_ack}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_vec", {29'b0, rq_ack}, {29'b0, 3'b001 << mon_e.who});
                    check("err_vec", {29'b0, rq_err}, {29'b0, mon_e.err ? (3'b001 << mon_e.who) : 3'b000});
                    check("rq_q", {16'b0, rq_q}, {16'b0, mon_e.q});
                end
            end
        end
    end

    // VDP responder: checks the presented cycle, then acks after 'delay' cycles or never.
    initial begin : vdp
        bus_t       p;
        int         n;
        bit         acked;
        logic [2:0] exp_cs;
        logic [2:0] exp_st;
        rd_data = 16'($urandom);
        forever begin
            @(negedge clk);
            if (rst_n && !(rd_n && lwr_n && uwr_n)) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", bus_q.size(), 1);
                    p = '{17'h0, 16'h0, 2'b00, 2'b00, 100000, 0, 16'h0};
                end else begin
                    p = bus_q.pop_front();
                end
                exp_cs = ~(3'b001 << p.sel);
                exp_st = (p.we == 2'b00) ? 3'b011 : {1'b1, ~p.we[1], ~p.we[0]};
                check("bus_a", {15'b0, a}, {15'b0, p.a});
                check("bus_do", {16'b0, wr_data}, {16'b0, p.d});
                check("bus_strobes", {29'b0, rd_n, uwr_n, lwr_n}, {29'b0, exp_st});
                check("bus_cs", {29'b0, dram_cs_n, pal_cs_n, reg_cs_n}, {29'b0, exp_cs});
                n     = 0;
                acked = 0;
                while (n < 2000) begin
                    if (rd_n && lwr_n && uwr_n) break;
                    if (n >= p.delay) begin
                        rd_data = p.di;
                        ack_n   = 1'b0;
                        acked   = 1;
                        break;
                    end
                    @(negedge clk);
                    n++;
                end
                if (acked) begin
                    n = 0;
                    while (!(rd_n && lwr_n && uwr_n) && n < 50) begin
                        @(negedge clk);
                        n++;
                    end
                    check("release_strobes", {29'b0, rd_n, lwr_n, uwr_n}, 32'h7);
                    check("release_do", {16'b0, wr_data}, {16'b0, p.d});
                    repeat (p.hold) @(negedge clk);
                    ack_n   = 1'b1;
                    rd_data = 16'($urandom);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        for (int b = 0; b < 3; b++) rand_req(b);
        repeat (3) @(negedge clk);
        check("rst_strobes", {29'b0, rd_n, lwr_n, uwr_n}, 32'h7);
        check("rst_cs", {29'b0, reg_cs_n, pal_cs_n, dram_cs_n}, 32'h7);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a", {15'b0, a}, 0);
        check("rst_do", {16'b0, wr_data}, 0);
        check("rst_q", {16'b0, rq_q}, 0);
        check("rst_ack", {26'b0, rq_ack, rq_err}, 0);

        // SH2 #1 reads REG 00002h, VDP acks two cycles after the strobe.
        rand_req(1);
        s_a[1] = 17'h00002; s_we[1] = 2'b00; s_sel[1] = 2'd0;
        s_delay[1] = 2; s_hold[1] = 0; s_di[1] = 16'h1234;
        run_round(3'b010, 1'b1, 0, 0);

        // 68K lower-byte write to DRAM.
        rand_req(0);
        s_a[0] = 17'h10000; s_d[0] = 16'hABCD; s_we[0] = 2'b01; s_sel[0] = 2'd2;
        s_delay[0] = 0; s_hold[0] = 1;
        run_round(3'b001, 1'b0, 0, 0);

        // SH2 request while the 68K owns the VDP.
        rand_req(2);
        s_sel[2] = 2'($urandom_range(0, 2));
        run_round(3'b100, 1'b0, 0, 0);

        // Both SH2s held for four transactions.
        for (int r = 0; r < 2; r++) begin
            rand_req(1); rand_req(2);
            s_sel[1] = 2'($urandom_range(0, 2));
            s_sel[2] = 2'($urandom_range(0, 2));
            run_round(3'b110, 1'b1, 0, 0);
        end

        // PAL reads: never acked, acked on the last WAIT cycle, one cycle too late.
        foreach (s_delay[i]) if (i == 1) begin
            rand_req(1);
            s_we[1] = 2'b00; s_sel[1] = 2'd1; s_delay[1] = 1000;
            run_round(3'b010, 1'b1, 0, 0);
            rand_req(1);
            s_we[1] = 2'b00; s_sel[1] = 2'd1; s_delay[1] = TO;
            run_round(3'b010, 1'b1, 0, 0);
            rand_req(1);
            s_we[1] = 2'b00; s_sel[1] = 2'd1; s_delay[1] = TO + 1;
            run_round(3'b010, 1'b1, 0, 0);
        end

        // Reset in the middle of WAIT.
        @(negedge clk);
        rand_req(1);
        s_we[1] = 2'b00; s_sel[1] = 2'd1; s_delay[1] = 1000;
        bus_q.push_back('{s_a[1], s_d[1], s_we[1], s_sel[1], s_delay[1], s_hold[1], s_di[1]});
        fm = 1'b1;
        rq_a[1] = s_a[1]; rq_d[1] = s_d[1]; rq_we[1] = s_we[1]; rq_sel[1] = s_sel[1];
        rq_req = 3'b010;
        repeat (5) @(negedge clk);
        check("pre_rst_rd", {31'b0, rd_n}, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_strobes", {29'b0, rd_n, lwr_n, uwr_n}, 32'h7);
        check("async_rst_cs", {29'b0, reg_cs_n, pal_cs_n, dram_cs_n}, 32'h7);
        check("async_rst_ack", {29'b0, rq_ack}, 0);
        rq_req = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mptr  = 0;
        for (int b = 0; b < 3; b++) rand_req(b);
        s_sel[0] = 2'($urandom_range(0, 2));
        run_round(3'b111, 1'b0, 0, 0);

        // Randomized rounds.
        for (int r = 0; r < 150; r++) begin
            logic [2:0] set;
            bit         tog;
            bit         drp;
            for (int b = 0; b < 3; b++) rand_req(b);
            set = 3'($urandom_range(1, 7));
            tog = ($countones(set) == 1) ? 1'($urandom) : 1'b0;
            drp = ($countones(set) == 1) ? 1'($urandom) : 1'b0;
            run_round(set, 1'($urandom), tog, drp);
        end

        repeat (4) @(negedge clk);
        check("exp_drained", exp_q.size(), 0);
        check("bus_drained", bus_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
